// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encoding, default operand width and iteration counter sizing.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must hold 0..WIDTH-1 with one spare bit of headroom.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate. Used as abs() on the operands
// (neg = operand sign bit) and as sign correction on the results.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  // Negate when requested, pass through otherwise.
  always_comb begin
    res = neg ? ((~val) + W'(1)) : val;
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiply/divide unit feeding the HI/LO registers.
// One radix-2 step per cycle: shift-add multiply (LSB first) and restoring
// divide (MSB first). Operands are converted to magnitudes on accept and the
// sign is restored on entry to DONE.
//
// Build option: MULDIV_DIV_EN. When undefined, the divider datapath is left
// out and a divide request completes after one CALC cycle with hi = lo = 0
// and dbz = 1.
//
// Handshake: start/op/a/b form a request that is accepted on any rising edge
// where start = 1 and the unit is IDLE or DONE (busy = 0). There is no
// ready signal and no queue; start while busy is ignored. done/hi_en/lo_en
// pulse for one cycle with hi/lo valid, and hi/lo then hold until the next
// completion.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             hi_en,
  output logic             lo_en,
  output logic             dbz,
  output logic [1:0]       state_dbg
);

  localparam int CW = cnt_width(WIDTH);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_CALC = ST_CALC;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]         state_q;
  logic [CW-1:0]      cnt_q;
  logic               op_q;
  logic               neg_q;      // sign of product / quotient
  logic [WIDTH-1:0]   m_q;        // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0]   sh_q;       // multiplier (mul) or dividend->quotient (div)
  logic [2*WIDTH-1:0] acc_q;      // product accumulator, or remainder in low bits
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               dbz_q;

  logic               accept;
  logic               last;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   sh_step;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               res_dbz;

  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  muldiv_sign_fix #(.W(WIDTH)) u_abs_a (.val(a), .neg(a[WIDTH-1]), .res(abs_a));
  muldiv_sign_fix #(.W(WIDTH)) u_abs_b (.val(b), .neg(b[WIDTH-1]), .res(abs_b));

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (sh_q[0] ? m_q : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  muldiv_sign_fix #(.W(2*WIDTH)) u_prod_fix (.val(mul_next), .neg(neg_q), .res(prod_fix));

`ifdef MULDIV_DIV_EN
  logic               rneg_q;     // remainder takes the dividend's sign
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Restoring divide step: bring in the next dividend bit, trial-subtract the
  // divisor, keep the difference only if it did not go negative.
  always_comb begin
    div_shift = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, m_q};
    div_rem   = div_diff[WIDTH+1] ? div_shift : div_diff[WIDTH:0];
    div_quo   = {sh_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
  end

  muldiv_sign_fix #(.W(WIDTH)) u_quo_fix (.val(div_quo), .neg(neg_q), .res(quo_fix));
  muldiv_sign_fix #(.W(WIDTH)) u_rem_fix (.val(div_rem[WIDTH-1:0]), .neg(rneg_q), .res(rem_fix));

  assign last = (cnt_q == CW'(WIDTH - 1));
`else
  // Without the divider a divide request finishes after its first CALC cycle.
  assign last = (op_q == OP_DIV) || (cnt_q == CW'(WIDTH - 1));
`endif

  // Select the per-cycle update and the final, sign-corrected result.
  always_comb begin
    acc_step = mul_next;
    sh_step  = sh_q >> 1;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    res_dbz  = 1'b0;
`ifdef MULDIV_DIV_EN
    if (op_q == OP_DIV) begin
      acc_step = {{(WIDTH-1){1'b0}}, div_rem};
      sh_step  = div_quo;
      res_hi   = rem_fix;                       // equals a when the divisor is 0
      res_lo   = (m_q == '0) ? '1 : quo_fix;
      res_dbz  = (m_q == '0);
    end
`else
    if (op_q == OP_DIV) begin
      res_hi  = '0;
      res_lo  = '0;
      res_dbz = 1'b1;
    end
`endif
  end

  // FSM, iteration counter, datapath registers and result registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      m_q     <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      rneg_q  <= 1'b0;
`endif
    end else if (accept) begin
      state_q <= S_CALC;
      cnt_q   <= '0;
      op_q    <= op;
      neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
      acc_q   <= '0;
      dbz_q   <= 1'b0;
      if (op == OP_DIV) begin
        m_q  <= abs_b;
        sh_q <= abs_a;
      end else begin
        m_q  <= abs_a;
        sh_q <= abs_b;
      end
`ifdef MULDIV_DIV_EN
      rneg_q  <= a[WIDTH-1];
`endif
    end else begin
      case (state_q)
        S_CALC: begin
          acc_q <= acc_step;
          sh_q  <= sh_step;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            state_q <= S_DONE;
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            dbz_q   <= res_dbz;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == S_CALC);
  assign done      = (state_q == S_DONE);
  assign hi_en     = done;
  assign lo_en     = done;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbz       = dbz_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed cases, back-to-back issue, start
// during CALC, asynchronous clear mid-operation and randomized operations
// checked against an arithmetic reference model. Honours MULDIV_DIV_EN.
`timescale 1ns/1ps
module tb_mul_div_unit;

  localparam int W = 32;
`ifdef MULDIV_DIV_EN
  localparam int DIV_LAT = W;
`else
  localparam int DIV_LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         hi_en;
  logic         lo_en;
  logic         dbz;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected results, packed as {dbz, hi, lo}.
  logic [2*W:0] exp_q[$];

  // Clock / reset block.
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .hi_en(hi_en), .lo_en(lo_en),
    .dbz(dbz), .state_dbg(state_dbg)
  );

  // Reference model: signed arithmetic on 64-bit integers.
  function automatic logic [2*W:0] model(input logic o, input logic [W-1:0] ai, input logic [W-1:0] bi);
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    logic [W-1:0] h;
    logic [W-1:0] l;
    logic z;
    sa = longint'($signed(ai));
    sb = longint'($signed(bi));
    if (o == 1'b0) begin
      p = sa * sb;
      h = p[2*W-1:W];
      l = p[W-1:0];
      z = 1'b0;
    end else begin
`ifdef MULDIV_DIV_EN
      if (sb == 0) begin
        l = '1;
        h = ai;
        z = 1'b1;
      end else begin
        q = sa / sb;
        r = sa % sb;
        l = q[W-1:0];
        h = r[W-1:0];
        z = 1'b0;
      end
`else
      q = 0;
      r = 0;
      h = q[W-1:0];
      l = r[W-1:0];
      z = 1'b1;
`endif
    end
    return {z, h, l};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Driver: issue one operation (called right after a falling edge) and check it.
  task automatic run_op(input string tag, input logic o, input logic [W-1:0] ai, input logic [W-1:0] bi);
    logic [2*W:0] e;
    int lat;
    int exp_lat;
    exp_lat = (o == 1'b1) ? DIV_LAT : W;
    exp_q.push_back(model(o, ai, bi));
    start = 1'b1; op = o; a = ai; b = bi;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_accept: got %b want 1", tag, busy); else n_pass++;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (lat !== exp_lat) $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat); else n_pass++;
    n_checks++;
    if (hi !== e[2*W-1:W]) $display("FAIL %s hi: got %h want %h", tag, hi, e[2*W-1:W]); else n_pass++;
    n_checks++;
    if (lo !== e[W-1:0]) $display("FAIL %s lo: got %h want %h", tag, lo, e[W-1:0]); else n_pass++;
    n_checks++;
    if (dbz !== e[2*W]) $display("FAIL %s dbz: got %b want %b", tag, dbz, e[2*W]); else n_pass++;
    n_checks++;
    if (hi_en !== 1'b1 || lo_en !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s done_flags: got hi_en=%b lo_en=%b busy=%b want 1 1 0", tag, hi_en, lo_en, busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || hi !== e[2*W-1:W] || lo !== e[W-1:0])
      $display("FAIL %s hold_after_done: got done=%b hi=%h lo=%h want 0 %h %h", tag, done, hi, lo,
               e[2*W-1:W], e[W-1:0]);
    else n_pass++;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, hi_en, lo_en, dbz} !== 5'b0 || hi !== '0 || lo !== '0 || state_dbg !== 2'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b hi_en=%b lo_en=%b dbz=%b hi=%h lo=%h st=%0d want all 0",
               busy, done, hi_en, lo_en, dbz, hi, lo, state_dbg);
    else n_pass++;
    clr = 1'b0;
  endtask

  task automatic test_directed();
    run_op("mul_m3x5", 1'b0, -32'sd3, 32'sd5);
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1)
      $display("FAIL mul_m3x5_const: got %h_%h want ffffffff_fffffff1", hi, lo);
    else n_pass++;
    run_op("div_m7d2", 1'b1, -32'sd7, 32'sd2);
    run_op("div_100d0", 1'b1, 32'd100, 32'd0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (dbz !== 1'b1) $display("FAIL dbz_held: got %b want 1", dbz); else n_pass++;
    run_op("mul_pos", 1'b0, 32'd12345, 32'd678);
    n_checks++;
    if (dbz !== 1'b0) $display("FAIL dbz_cleared: got %b want 0", dbz); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2*W:0] e;
    int lat;
    int gap;
    start = 1'b1; op = 1'b0; a = 32'h8000_0000; b = 32'h8000_0000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== W || hi !== 32'h4000_0000 || lo !== 32'h0)
      $display("FAIL b2b_mul_min: got lat=%0d hi=%h lo=%h want %0d 40000000 00000000", lat, hi, lo, W);
    else n_pass++;
    e = model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    start = 1'b1; op = 1'b1; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    while (done !== 1'b1 && gap < 300) begin
      @(negedge clk);
      gap++;
    end
    n_checks++;
    if (gap !== DIV_LAT + 1) $display("FAIL b2b_gap: got %0d want %0d", gap, DIV_LAT + 1); else n_pass++;
    n_checks++;
    if (hi !== e[2*W-1:W] || lo !== e[W-1:0] || dbz !== e[2*W])
      $display("FAIL b2b_div_ovf: got hi=%h lo=%h dbz=%b want %h %h %b", hi, lo, dbz,
               e[2*W-1:W], e[W-1:0], e[2*W]);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] ai;
    logic [W-1:0] bi;
    logic [2*W:0] e;
    logic [W-1:0] got_hi;
    logic [W-1:0] got_lo;
    int ndone;
    int done_at;
    ai = $urandom; bi = $urandom;
    e = model(1'b0, ai, bi);
    got_hi = '0; got_lo = '0;
    start = 1'b1; op = 1'b0; a = ai; b = bi;
    @(posedge clk);
    ndone = 0; done_at = -1;
    for (int c = 0; c < W + 6; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        done_at = c;
        got_hi = hi;
        got_lo = lo;
      end
      if (c < W - 1) begin
        start = 1'b1; op = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    n_checks++;
    if (ndone !== 1 || done_at !== W)
      $display("FAIL start_ignored_done: got count=%0d at=%0d want 1 at %0d", ndone, done_at, W);
    else n_pass++;
    n_checks++;
    if (got_hi !== e[2*W-1:W] || got_lo !== e[W-1:0])
      $display("FAIL start_ignored_result: got %h_%h want %h_%h", got_hi, got_lo, e[2*W-1:W], e[W-1:0]);
    else n_pass++;
  endtask

  task automatic test_clr_mid();
    int seen_done;
    run_op("pre_clr", 1'b0, 32'd77, 32'd99);
    start = 1'b1; op = 1'b0; a = 32'd1234; b = 32'd5678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL clr_pre_busy: got %b want 1", busy); else n_pass++;
    clr = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, hi_en, lo_en, dbz} !== 5'b0 || hi !== '0 || lo !== '0 || state_dbg !== 2'd0)
      $display("FAIL clr_async: got busy=%b done=%b hi_en=%b lo_en=%b dbz=%b hi=%h lo=%h st=%0d want all 0",
               busy, done, hi_en, lo_en, dbz, hi, lo, state_dbg);
    else n_pass++;
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    n_checks++;
    if (seen_done !== 0) $display("FAIL clr_quiet: got %0d active cycles want 0", seen_done); else n_pass++;
    clr = 1'b0;
    run_op("after_clr", 1'b0, -32'sd9, 32'sd11);
  endtask

  task automatic test_random();
    logic o;
    for (int i = 0; i < 40; i++) begin
      o = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d_%s", i, o ? "div" : "mul"), o, pick(), pick());
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_directed();
    test_back_to_back();
    test_start_ignored();
    test_clr_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit signed multiply/divide unit for the CPU datapath. It sits directly upstream of the HI and LO 32-bit registers. It takes operands from the A/B bus registers and, on completion, presents a 64-bit result with single-cycle write-enable pulses that drive the HI/LO register `enable` inputs. It uses one radix-2 iteration per cycle, so each operation has a fixed latency.

## Interface
- `WIDTH`, default 32: operand width. Result is 2×WIDTH.
- `clk` in 1: rising-edge clock.
- `clr` in 1: asynchronous, active-high reset.
- `start` in 1: request an operation. Sampled only in IDLE or DONE.
- `op` in 1: 0 = multiply, 1 = divide. Sampled with `start`.
- `a` in WIDTH: multiplicand or dividend (signed). Sampled with `start`.
- `b` in WIDTH: multiplier or divisor (signed). Sampled with `start`.
- `busy` out 1: high from the accept cycle through the last CALC cycle.
- `done` out 1: one-cycle pulse; `hi`/`lo` are valid in this cycle.
- `hi` out WIDTH: product upper half, or remainder.
- `lo` out WIDTH: product lower half, or quotient.
- `hi_en`, `lo_en` out 1: equal to `done`. Connect to the HI/LO register enables.
- `dbz` out 1: divide-by-zero flag. Valid with `done`, held until the next accept.

## Operation
- State machine: IDLE → CALC (WIDTH cycles) → DONE (1 cycle) → IDLE.
  - DONE goes to CALC instead if `start` is high in the DONE cycle.
- Accept (IDLE or DONE with `start`=1):
  - latch `op`;
  - latch |a| and |b| as unsigned;
  - latch the result sign: sign(a) XOR sign(b) for the product/quotient, sign(a) for the remainder;
  - clear the accumulator and the iteration counter.
- `start` while in CALC is ignored. No queuing.
- Multiply: unsigned shift-add over a 2×WIDTH accumulator, one multiplier bit per cycle, LSB first.
- Divide: restoring shift-subtract, one quotient bit per cycle, MSB first. Remainder is WIDTH+1 bits internally.
- Sign fix is applied on entry to DONE.
  - Product: negate the 2×WIDTH result if the sign bit is set.
  - Quotient: negate if the sign bit is set.
  - Remainder: takes the dividend's sign.
- Divide by zero (b = 0):
  - full latency is still taken;
  - result is lo = all ones, hi = a, dbz = 1.
- Overflow case −2^(WIDTH−1) / −1: lo = 0x80000000, hi = 0. `dbz` is not set.
- Multiply by −2^(WIDTH−1) is exact, because the 2×WIDTH result never overflows.
- `hi`/`lo` hold their last result until the next DONE. They are not cleared on accept.

## Timing
- Accept on edge N: `busy`=1 after edge N.
- CALC occupies the cycles after edges N…N+WIDTH−1.
- Edge N+WIDTH enters DONE: `done`/`hi_en`/`lo_en`=1 and `busy`=0 for exactly one cycle.
- Latency from the accept edge to `done` is WIDTH cycles. With a back-to-back `start` in DONE, throughput is one operation per WIDTH+1 cycles.
- `clr` asserted at any time, including mid-CALC or in DONE:
  - state returns to IDLE immediately;
  - busy = done = hi_en = lo_en = dbz = 0;
  - hi = lo = 0;
  - the operation in flight is discarded.
- `clr` release takes effect on the first clock edge afterwards. `start` on that edge is accepted.
- Reset value of every output: 0.

## Configuration
- `MULDIV_DIV_EN` defined: full divide path as above.
- `MULDIV_DIV_EN` undefined: the divider datapath is not compiled.
  - Accept with `op`=1 goes straight to DONE on the next edge (1-cycle latency).
  - Result is hi = lo = 0, dbz = 1.
  - Multiply is unchanged.

## Structure
- Shared package `muldiv_pkg` holds:
  - `OP_MUL`/`OP_DIV` constants;
  - the state enum (IDLE, CALC, DONE);
  - default `WIDTH` = 32;
  - counter width = $clog2(WIDTH)+1.
- One natural sub-module, `muldiv_sign_fix`: combinational abs/negate helper for operand conditioning and result correction, instantiated at input and output.
- The FSM, counter and accumulators stay in `mul_div_unit`.

## Test plan
- Multiply a=−3, b=5 → `done` exactly 32 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFF1; hi_en=lo_en=1 for one cycle.
- Divide a=−7, b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1), dbz=0.
- Divide a=100, b=0 → lo=0xFFFFFFFF, hi=100, dbz=1 after 32 cycles. Without `MULDIV_DIV_EN`: hi=lo=0, dbz=1 after 1 cycle.
- Multiply 0x80000000 × 0x80000000 → hi=0x40000000, lo=0; then `start` in the DONE cycle with divide 0x80000000 / −1 → lo=0x80000000, hi=0 exactly 33 cycles after the first `done`.
- Assert `clr` on CALC cycle 10 → all outputs 0 immediately, no `done`. `start` on the first edge after release completes normally.
- Pulse `start` every cycle during CALC → exactly one `done` per accepted operation, and the result matches the first operands.
